// File: rtl/mem_bus_master.sv
// mem_bus_master: MEM-stage load/store to Wishbone classic master with error and timeout termination
module mem_bus_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t     state, state_d;
    logic [7:0] cnt;
    logic       mis, term, tout, accept;
    always_comb begin
        mis     = |addr_i[1:0];
        term    = wb_ack_i | wb_err_i;
        tout    = cnt == 8'(TIMEOUT - 1);
        accept  = state == IDLE && req_i;
        state_d = (state == IDLE) ? (req_i ? (mis ? RESP : BUS) : IDLE) :
                  (state == BUS)  ? ((term || tout) ? RESP : BUS) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rdata_o  <= '0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            busy_o   <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
        end else begin
            cnt      <= (state == BUS) ? cnt + 8'd1 : 8'd0;
            done_o   <= state_d == RESP;
            busy_o   <= state_d != IDLE;
            wb_cyc_o <= state_d == BUS;
            wb_stb_o <= state_d == BUS;
            wb_sel_o <= {4{state_d == BUS}};
            wb_we_o  <= (state == IDLE) ? (req_i & we_i & ~mis) : (wb_we_o & (state_d == BUS));
            // ack coinciding with the last allowed wait cycle counts as success, not timeout
            err_o    <= (accept && mis) || (state == BUS && (wb_err_i || (!wb_ack_i && tout)));
            if (accept) begin
                wb_adr_o <= {addr_i[31:2], 2'b00};
                wb_dat_o <= wdata_i;
            end
            if (state == BUS && wb_ack_i && !wb_err_i && !wb_we_o) rdata_o <= wb_dat_i;
        end
    end
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed and randomized transactions checked against a transaction-level model
module tb_mem_bus_master;
    localparam int TO = 4;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_i = 1'b0, we_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0, wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
    logic [31:0] rdata_o, wb_adr_o, wb_dat_o;
    logic        done_o, err_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    int          checks = 0, errors = 0;
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    mem_bus_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 ack, 1 err, 2 ack+err, 3 silent slave; w = wait cycles before the slave answers
    function automatic void predict(input logic [31:0] addr, input int w, input int kind,
                                    output int stb, output logic err);
        if (addr[1:0] != 2'b00) begin
            stb = 0;
            err = 1'b1;
        end else if (kind == 3 || w + 1 > TO) begin
            stb = TO;
            err = 1'b1;
        end else begin
            stb = w + 1;
            err = kind != 0;
        end
    endfunction

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdat, input int w, input int kind, input bit stray);
        int   stb_n, done_at, exp_stb;
        logic exp_err, got_err;
        logic [31:0] got_rdata;
        predict(addr, w, kind, exp_stb, exp_err);
        if (!we && !exp_err) exp_rdata = rdat;
        we_i = we; addr_i = addr; wdata_i = wdata; wb_dat_i = rdat; req_i = 1'b1;
        step();
        req_i = 1'b0;
        stb_n = 0; done_at = -1; got_err = 1'bx; got_rdata = 'x;
        for (int c = 1; c <= TO + 3 && done_at < 0; c++) begin
            chk("busy", {31'd0, busy_o}, 32'd1);
            chk("cyc_vs_stb", {31'd0, wb_cyc_o}, {31'd0, wb_stb_o});
            if (wb_stb_o) begin
                stb_n++;
                chk("adr", wb_adr_o, {addr[31:2], 2'b00});
                chk("we", {31'd0, wb_we_o}, {31'd0, we});
                chk("sel", {28'd0, wb_sel_o}, 32'hF);
                if (we) chk("wdat", wb_dat_o, wdata);
            end
            if (done_o) begin
                done_at = c;
                got_err = err_o;
                got_rdata = rdata_o;
            end else chk("err_idle", {31'd0, err_o}, 32'd0);
            wb_ack_i = wb_stb_o && stb_n == w + 1 && (kind == 0 || kind == 2);
            wb_err_i = wb_stb_o && stb_n == w + 1 && (kind == 1 || kind == 2);
            req_i = stray ? 1'($urandom_range(1)) : 1'b0;
            addr_i = $urandom;
            we_i = 1'($urandom_range(1));
            step();
        end
        req_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        chk("done_cycle", 32'(done_at), 32'(exp_stb + 1));
        chk("stb_cycles", 32'(stb_n), 32'(exp_stb));
        chk("err", {31'd0, got_err}, {31'd0, exp_err});
        chk("rdata", got_rdata, exp_rdata);
        chk("post_done", {31'd0, done_o}, 32'd0);
        chk("post_busy", {31'd0, busy_o}, 32'd0);
        chk("post_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("post_err", {31'd0, err_o}, 32'd0);
        wb_ack_i = 1'b1; wb_err_i = 1'($urandom_range(1)); wb_dat_i = $urandom;
        step();
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        chk("stray_ack_done", {31'd0, done_o}, 32'd0);
        chk("stray_ack_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("stray_ack_rdata", rdata_o, exp_rdata);
    endtask

    initial begin
        logic [31:0] a;
        step();
        step();
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_we", {31'd0, wb_we_o}, 32'd0);
        chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_flags", {29'd0, done_o, err_o, busy_o}, 32'd0);
        rst = 1'b0;
        step();
        txn(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
        txn(1'b1, 32'h204, 32'h12345678, 32'hCAFEF00D, 3, 0, 1'b0);
        txn(1'b0, 32'h102, 32'h0, 32'h11111111, 0, 0, 1'b0);
        txn(1'b0, 32'h108, 32'h0, 32'h22222222, 0, 3, 1'b0);
        txn(1'b0, 32'h10C, 32'h0, 32'h33333333, 1, 2, 1'b0);
        txn(1'b1, 32'h110, 32'hA5A5A5A5, 32'h0, 0, 1, 1'b1);
        txn(1'b0, 32'h114, 32'h0, 32'h44444444, TO - 1, 0, 1'b1);
        we_i = 1'b0; addr_i = 32'h300; wb_dat_i = 32'h5555AAAA; req_i = 1'b1;
        step();
        chk("mid_stb", {31'd0, wb_stb_o}, 32'd1);
        addr_i = 32'h400; we_i = 1'b1; req_i = 1'b1;
        step();
        req_i = 1'b0;
        chk("mid_busy", {31'd0, busy_o}, 32'd1);
        chk("mid_adr_kept", wb_adr_o, 32'h300);
        chk("mid_we_kept", {31'd0, wb_we_o}, 32'd0);
        rst = 1'b1;
        #1;
        exp_rdata = '0;
        chk("async_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("async_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("async_flags", {29'd0, done_o, err_o, busy_o}, 32'd0);
        chk("async_rdata", rdata_o, 32'd0);
        step();
        rst = 1'b0;
        wb_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("late_ack_done", {31'd0, done_o}, 32'd0);
            chk("late_ack_cyc", {31'd0, wb_cyc_o}, 32'd0);
            chk("late_ack_rdata", rdata_o, exp_rdata);
        end
        wb_ack_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(4) != 0) a[1:0] = 2'b00;
            txn(1'($urandom_range(1)), a, $urandom, $urandom, int'($urandom_range(TO + 1)),
                int'($urandom_range(3)), 1'($urandom_range(1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
